pc_ctrl: RTL and testbench

Sequencer for the 64-bit program counter register. Generates the counter's write-enable, load value and stall from a boot sequence, three redirect sources and the instruction-memory handshake. Also emits the IF/ID flush pulse. Sits between the execute/trap logic and the PC register in the fetch stage.

---
 rtl/pc_ctrl.sv | 145 ++++++++++++++
 tb/tb_pc_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_ctrl : PC write-enable / load / stall sequencer with boot, redirects    |
// |           and IF/ID flush. Optional trap path: define PC_CTRL_TRAP_EN.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pc_ctrl #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BOOT_DELAY   = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_hazard_stall,
  input  logic            i_imem_ready,
  output logic            o_imem_req,
  input  logic            i_br_taken,
  input  logic [XLEN-1:0] i_br_target,
  input  logic            i_jmp,
  input  logic [XLEN-1:0] i_jmp_target,
`ifdef PC_CTRL_TRAP_EN
  input  logic            i_trap,
  input  logic [XLEN-1:0] i_trap_vec,
`endif
  output logic            o_pc_we,
  output logic [XLEN-1:0] o_pc_next,
  output logic            o_pc_stall,
  output logic            o_flush
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [7:0]      C_BOOT_LOAD  = 8'(BOOT_DELAY - 1);
  localparam logic [XLEN-1:0] C_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pend_q, pend_d;

  logic            w_redir;
  logic [XLEN-1:0] w_tgt_raw;
  logic [XLEN-1:0] w_tgt;

`ifdef PC_CTRL_TRAP_EN
  logic [XLEN-1:0] w_trap_tgt;
  assign w_trap_tgt = i_trap_vec & C_ALIGN_MASK;
  assign w_redir    = i_trap | i_br_taken | i_jmp;
  assign w_tgt_raw  = i_trap     ? i_trap_vec  :
                      i_br_taken ? i_br_target : i_jmp_target;
`else
  assign w_redir    = i_br_taken | i_jmp;
  assign w_tgt_raw  = i_br_taken ? i_br_target : i_jmp_target;
`endif

  assign w_tgt = w_tgt_raw & C_ALIGN_MASK;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    o_pc_we    = 1'b0;
    o_pc_next  = w_tgt;
    o_pc_stall = 1'b1;
    o_imem_req = 1'b0;
    o_flush    = 1'b0;

    case (state_q)
      ST_BOOT: begin
        o_pc_next = RESET_VECTOR;
        if (cnt_q == 8'd0) begin
          o_pc_we = 1'b1;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_RUN: begin
        if (w_redir) begin
          // A redirect wins over the hazard stall; memory readiness decides
          // whether the load happens now or is parked in HOLD.
          o_flush = 1'b1;
          if (i_imem_ready) begin
            o_pc_we    = 1'b1;
            o_pc_stall = 1'b0;
          end else begin
            pend_d  = w_tgt;
            state_d = ST_HOLD;
          end
        end else begin
          o_imem_req = !i_hazard_stall;
          o_pc_stall = i_hazard_stall | !i_imem_ready;
        end
      end

      ST_HOLD: begin
        o_pc_next = pend_q;
`ifdef PC_CTRL_TRAP_EN
        if (i_trap) begin
          o_flush   = 1'b1;
          pend_d    = w_trap_tgt;
          o_pc_next = w_trap_tgt;
        end
`endif
        if (i_imem_ready) begin
          o_pc_we = 1'b1;
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
        cnt_d   = C_BOOT_LOAD;
      end
    endcase

    // Outputs must read their reset values while reset is held, even for
    // BOOT_DELAY=1 where the reloaded counter is already zero.
    if (i_rst) begin
      o_pc_we    = 1'b0;
      o_pc_stall = 1'b1;
      o_imem_req = 1'b0;
      o_flush    = 1'b0;
      o_pc_next  = RESET_VECTOR;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_BOOT;
      cnt_q   <= C_BOOT_LOAD;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// Directed self-checking bench for pc_ctrl with a simple PC register model.
module tb_pc_ctrl;

  localparam int          XLEN = 64;
  localparam logic [63:0] RV   = 64'h100;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            hazard = 1'b0, ready = 1'b1;
  logic            br = 1'b0, jmp = 1'b0;
  logic [XLEN-1:0] brt = '0, jmpt = '0;
`ifdef PC_CTRL_TRAP_EN
  logic            trap = 1'b0;
  logic [XLEN-1:0] trapv = '0;
`endif
  logic            we, stall, req, flush;
  logic [XLEN-1:0] nxt;
  logic [XLEN-1:0] pc;
  logic [3:0]      ctl;

  int vecs = 0;
  int errs = 0;

  assign ctl = {we, stall, req, flush};

  always #5 clk = ~clk;

  pc_ctrl #(.XLEN(XLEN), .RESET_VECTOR(RV), .BOOT_DELAY(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_hazard_stall(hazard), .i_imem_ready(ready),
    .o_imem_req(req), .i_br_taken(br), .i_br_target(brt), .i_jmp(jmp),
    .i_jmp_target(jmpt),
`ifdef PC_CTRL_TRAP_EN
    .i_trap(trap), .i_trap_vec(trapv),
`endif
    .o_pc_we(we), .o_pc_next(nxt), .o_pc_stall(stall), .o_flush(flush)
  );

  always @(posedge clk or posedge rst) begin
    if (rst)        pc <= '0;
    else if (we)    pc <= nxt;
    else if (!stall) pc <= pc + 64'd4;
  end

  task automatic idle();
    hazard = 1'b0; br = 1'b0; jmp = 1'b0;
`ifdef PC_CTRL_TRAP_EN
    trap = 1'b0;
`endif
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // ctl = {we, stall, req, flush}
  task automatic test_reset();
    #1;
    if (ctl !== 4'b0100) begin $display("FAIL reset_ctl got %b want %b", ctl, 4'b0100); errs++; end
    vecs++;
    if (nxt !== RV) begin $display("FAIL reset_next got %h want %h", nxt, RV); errs++; end
    vecs++;
  endtask

  task automatic test_boot(input string tag);
    logic [3:0] exp;
    next_cycle();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      exp = (i < 4) ? 4'b0100 : 4'b1100;
      if (ctl !== exp) begin $display("FAIL %s_cyc%0d_ctl got %b want %b", tag, i, ctl, exp); errs++; end
      vecs++;
    end
    if (nxt !== RV) begin $display("FAIL %s_next got %h want %h", tag, nxt, RV); errs++; end
    vecs++;
    @(negedge clk);
    if (ctl !== 4'b0010) begin $display("FAIL %s_run_ctl got %b want %b", tag, ctl, 4'b0010); errs++; end
    vecs++;
    if (pc !== RV) begin $display("FAIL %s_pc0 got %h want %h", tag, pc, RV); errs++; end
    vecs++;
    @(negedge clk);
    if (pc !== RV + 64'd4) begin $display("FAIL %s_pc1 got %h want %h", tag, pc, RV + 64'd4); errs++; end
    vecs++;
  endtask

  task automatic test_simultaneous();
    next_cycle();
    br = 1'b1; brt = 64'h1000; jmp = 1'b1; jmpt = 64'h2000; ready = 1'b1;
    @(negedge clk);
    if (ctl !== 4'b1001) begin $display("FAIL simul_ctl got %b want %b", ctl, 4'b1001); errs++; end
    vecs++;
    if (nxt !== 64'h1000) begin $display("FAIL simul_next got %h want %h", nxt, 64'h1000); errs++; end
    vecs++;
    next_cycle();
    idle();
    @(negedge clk);
    if (ctl !== 4'b0010) begin $display("FAIL simul_after_ctl got %b want %b", ctl, 4'b0010); errs++; end
    vecs++;
    if (pc !== 64'h1000) begin $display("FAIL simul_pc got %h want %h", pc, 64'h1000); errs++; end
    vecs++;
    next_cycle();
    jmp = 1'b1; jmpt = 64'h2002;
    @(negedge clk);
    if (nxt !== 64'h2000) begin $display("FAIL jmp_align_next got %h want %h", nxt, 64'h2000); errs++; end
    vecs++;
    next_cycle();
    idle();
  endtask

  task automatic test_busy_memory();
    br = 1'b1; brt = 64'h1003; ready = 1'b0;
    @(negedge clk);
    if (ctl !== 4'b0101) begin $display("FAIL busy_redir_ctl got %b want %b", ctl, 4'b0101); errs++; end
    vecs++;
    next_cycle();
    brt = 64'h3000;  // wrong-path branch seen in HOLD
    @(negedge clk);
    if (ctl !== 4'b0100) begin $display("FAIL busy_hold1_ctl got %b want %b", ctl, 4'b0100); errs++; end
    vecs++;
    next_cycle();
    idle();
    @(negedge clk);
    if (ctl !== 4'b0100) begin $display("FAIL busy_hold2_ctl got %b want %b", ctl, 4'b0100); errs++; end
    vecs++;
    next_cycle();
    ready = 1'b1;
    @(negedge clk);
    if (ctl !== 4'b1100) begin $display("FAIL busy_load_ctl got %b want %b", ctl, 4'b1100); errs++; end
    vecs++;
    if (nxt !== 64'h1000) begin $display("FAIL busy_load_next got %h want %h", nxt, 64'h1000); errs++; end
    vecs++;
    next_cycle();
    @(negedge clk);
    if (pc !== 64'h1000) begin $display("FAIL busy_pc got %h want %h", pc, 64'h1000); errs++; end
    vecs++;
    if (ctl !== 4'b0010) begin $display("FAIL busy_run_ctl got %b want %b", ctl, 4'b0010); errs++; end
    vecs++;
    next_cycle();
  endtask

  task automatic test_hazard();
    hazard = 1'b1; ready = 1'b1;
    @(negedge clk);
    if (ctl !== 4'b0100) begin $display("FAIL hazard_ctl got %b want %b", ctl, 4'b0100); errs++; end
    vecs++;
    next_cycle();
    jmp = 1'b1; jmpt = 64'h40;
    @(negedge clk);
    if (ctl !== 4'b1001) begin $display("FAIL hazard_jmp_ctl got %b want %b", ctl, 4'b1001); errs++; end
    vecs++;
    if (nxt !== 64'h40) begin $display("FAIL hazard_jmp_next got %h want %h", nxt, 64'h40); errs++; end
    vecs++;
    next_cycle();
    idle(); ready = 1'b0;
    @(negedge clk);
    if (ctl !== 4'b0110) begin $display("FAIL notready_ctl got %b want %b", ctl, 4'b0110); errs++; end
    vecs++;
    next_cycle();
    ready = 1'b1;
  endtask

`ifdef PC_CTRL_TRAP_EN
  task automatic test_trap();
    trap = 1'b1; trapv = 64'h8000; br = 1'b1; brt = 64'h1000; jmp = 1'b1; jmpt = 64'h2000;
    @(negedge clk);
    if (nxt !== 64'h8000 || ctl !== 4'b1001) begin $display("FAIL trap_prio got %h/%b want %h/%b", nxt, ctl, 64'h8000, 4'b1001); errs++; end
    vecs++;
    next_cycle();
    idle(); br = 1'b1; brt = 64'h1000; ready = 1'b0;
    next_cycle();
    idle(); trap = 1'b1; trapv = 64'h8000;
    @(negedge clk);
    if (ctl !== 4'b0101) begin $display("FAIL trap_hold_ctl got %b want %b", ctl, 4'b0101); errs++; end
    vecs++;
    next_cycle();
    idle(); ready = 1'b1;
    @(negedge clk);
    if (nxt !== 64'h8000 || ctl !== 4'b1100) begin $display("FAIL trap_hold_load got %h/%b want %h/%b", nxt, ctl, 64'h8000, 4'b1100); errs++; end
    vecs++;
    next_cycle();
    br = 1'b1; brt = 64'h1000; ready = 1'b0;
    next_cycle();
    idle(); trap = 1'b1; trapv = 64'h9001; ready = 1'b1;
    @(negedge clk);
    if (nxt !== 64'h9000 || ctl !== 4'b1101) begin $display("FAIL trap_ready_load got %h/%b want %h/%b", nxt, ctl, 64'h9000, 4'b1101); errs++; end
    vecs++;
    next_cycle();
    idle();
  endtask
`endif

  task automatic test_reset_mid_hold();
    br = 1'b1; brt = 64'h1000; ready = 1'b0;
    next_cycle();
    idle();
    @(negedge clk);
    if (ctl !== 4'b0100) begin $display("FAIL midhold_pre_ctl got %b want %b", ctl, 4'b0100); errs++; end
    vecs++;
    #2 rst = 1'b1;
    test_reset();
    ready = 1'b1;
    next_cycle();
    test_boot("reboot");
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    next_cycle();
    test_boot("boot");
    test_simultaneous();
    test_busy_memory();
    test_hazard();
`ifdef PC_CTRL_TRAP_EN
    test_trap();
`endif
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
